uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: 8N1-style UART with independent TX/RX FSMs; even parity enabled by defining UART_PARITY_EN
module uart_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW = $clog2(STOP_BITS * DIV + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
`ifdef UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP,
        R_BREAK
    } rx_state_e;

    tx_state_e ts_q, ts_d;
    logic [CW-1:0] tc_q, tc_d;
    logic [3:0] tb_q, tb_d;
    logic [DATA_BITS-1:0] tsh_q, tsh_d;
    logic init_q;

    rx_state_e rs_q, rs_d;
    logic [1:0] sync_q;
    logic [CW-1:0] rc_q, rc_d;
    logic [3:0] rb_q, rb_d;
    logic [DATA_BITS-1:0] rsh_q, rsh_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic rvalid_q, rvalid_d;
    logic rferr_q, rferr_d;
    logic rxs;

`ifdef UART_PARITY_EN
    logic tpar_q, tpar_d;
    logic rpar_q, rpar_d;
    logic rperr_q, rperr_d;
`endif

    assign tx_ready = init_q && (ts_q == T_IDLE);
`ifdef UART_PARITY_EN
    assign tx = (ts_q == T_START) ? 1'b0 : (ts_q == T_DATA) ? tsh_q[0] : (ts_q == T_PARITY) ? tpar_q : 1'b1;
    assign rx_parity_err = rperr_q;
`else
    assign tx = (ts_q == T_START) ? 1'b0 : (ts_q == T_DATA) ? tsh_q[0] : 1'b1;
    assign rx_parity_err = 1'b0;
`endif
    assign rxs = sync_q[1];
    assign rx_data = rdata_q;
    assign rx_valid = rvalid_q;
    assign rx_frame_err = rferr_q;

    // TX next state: each line bit is held for DIV cycles, data shifted out LSB first
    always_comb begin
        ts_d = ts_q;
        tc_d = tc_q + CNT_ONE;
        tb_d = tb_q;
        tsh_d = tsh_q;
`ifdef UART_PARITY_EN
        tpar_d = tpar_q;
`endif
        case (ts_q)
            T_IDLE: begin
                tc_d = '0;
                if (tx_valid && tx_ready) begin
                    ts_d = T_START;
                    tsh_d = tx_data;
`ifdef UART_PARITY_EN
                    tpar_d = ^tx_data;
`endif
                end
            end
            T_START: if (tc_q == BIT_END) begin
                ts_d = T_DATA;
                tc_d = '0;
                tb_d = '0;
            end
            T_DATA: if (tc_q == BIT_END) begin
                tc_d = '0;
                tb_d = tb_q + 4'd1;
                tsh_d = tsh_q >> 1;
`ifdef UART_PARITY_EN
                if (tb_q == LAST_BIT) ts_d = T_PARITY;
`else
                if (tb_q == LAST_BIT) ts_d = T_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            T_PARITY: if (tc_q == BIT_END) begin
                ts_d = T_STOP;
                tc_d = '0;
            end
`endif
            T_STOP: if (tc_q == STOP_END) begin
                ts_d = T_IDLE;
                tc_d = '0;
            end
            default: begin
                ts_d = T_IDLE;
                tc_d = '0;
            end
        endcase
    end

    // TX state register; init_q holds off tx_ready until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= T_IDLE;
            tc_q <= '0;
            tb_q <= '0;
            tsh_q <= '0;
            init_q <= 1'b0;
`ifdef UART_PARITY_EN
            tpar_q <= 1'b0;
`endif
        end else begin
            ts_q <= ts_d;
            tc_q <= tc_d;
            tb_q <= tb_d;
            tsh_q <= tsh_d;
            init_q <= 1'b1;
`ifdef UART_PARITY_EN
            tpar_q <= tpar_d;
`endif
        end
    end

    // RX next state: confirm start at half a bit, then sample every DIV cycles at mid-bit
    always_comb begin
        rs_d = rs_q;
        rc_d = rc_q + CNT_ONE;
        rb_d = rb_q;
        rsh_d = rsh_q;
        rdata_d = rdata_q;
        rvalid_d = 1'b0;
        rferr_d = 1'b0;
`ifdef UART_PARITY_EN
        rpar_d = rpar_q;
        rperr_d = 1'b0;
`endif
        case (rs_q)
            R_IDLE: begin
                rc_d = '0;
                if (!rxs) rs_d = R_START;
            end
            R_START: if (rc_q == HALF_END) begin
                rc_d = '0;
                rb_d = '0;
                rs_d = rxs ? R_IDLE : R_DATA;
            end
            R_DATA: if (rc_q == BIT_END) begin
                rc_d = '0;
                rb_d = rb_q + 4'd1;
                rsh_d = {rxs, rsh_q[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
                if (rb_q == LAST_BIT) rs_d = R_PARITY;
`else
                if (rb_q == LAST_BIT) rs_d = R_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            R_PARITY: if (rc_q == BIT_END) begin
                rc_d = '0;
                rpar_d = rxs;
                rs_d = R_STOP;
            end
`endif
            R_STOP: if (rc_q == BIT_END) begin
                rc_d = '0;
                rvalid_d = 1'b1;
                rdata_d = rsh_q;
                rferr_d = !rxs;
`ifdef UART_PARITY_EN
                rperr_d = ^{rsh_q, rpar_q};
`endif
                rs_d = rxs ? R_IDLE : R_BREAK;
            end
            R_BREAK: begin
                rc_d = '0;
                if (rxs) rs_d = R_IDLE;
            end
            default: begin
                rs_d = R_IDLE;
                rc_d = '0;
            end
        endcase
    end

    // RX state register and two-flop synchronizer for the asynchronous rx line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            rs_q <= R_IDLE;
            rc_q <= '0;
            rb_q <= '0;
            rsh_q <= '0;
            rdata_q <= '0;
            rvalid_q <= 1'b0;
            rferr_q <= 1'b0;
`ifdef UART_PARITY_EN
            rpar_q <= 1'b0;
            rperr_q <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rx};
            rs_q <= rs_d;
            rc_q <= rc_d;
            rb_q <= rb_d;
            rsh_q <= rsh_d;
            rdata_q <= rdata_d;
            rvalid_q <= rvalid_d;
            rferr_q <= rferr_d;
`ifdef UART_PARITY_EN
            rpar_q <= rpar_d;
            rperr_q <= rperr_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized bench for uart_core against a per-cycle line model and an expected-frame queue
module tb_uart_core;
    localparam int DIV = 10;
`ifdef UART_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic tx_ready, tx, rx;
    logic [7:0] rx_data;
    logic rx_valid, rx_frame_err, rx_parity_err;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;

    int nvec = 0;
    int nerr = 0;
    bit txq[$];
    logic [9:0] rq[$];
    logic [7:0] last_d = '0;
    bit acc = 1'b0;
    bit rst_ok = 1'b0;

    assign rx = loop ? tx : rx_drv;

    uart_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
        .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_ok <= 1'b0;
        else rst_ok <= 1'b1;
    end

    always @(negedge clk) begin
        bit exp_rdy, exp_tx;
        logic [9:0] e;
        if (!rst_n) begin
            txq.delete();
            rq.delete();
            last_d = '0;
            acc = 1'b0;
            check("rst_tx", tx, 1);
            check("rst_ready", tx_ready, 0);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_rx_data", rx_data, 0);
            check("rst_err_flags", {rx_frame_err, rx_parity_err}, 0);
        end else begin
            exp_rdy = rst_ok && (txq.size() == 0);
            exp_tx = (txq.size() != 0) ? txq.pop_front() : 1'b1;
            check("tx_line", tx, exp_tx);
            check("tx_ready", tx_ready, exp_rdy);
            acc = tx_valid && exp_rdy;
            if (acc) begin
                for (int k = 0; k < DIV; k++) txq.push_back(1'b0);
                for (int i = 0; i < 8; i++) for (int k = 0; k < DIV; k++) txq.push_back(tx_data[i]);
                if (PEN) for (int k = 0; k < DIV; k++) txq.push_back(^tx_data);
                for (int k = 0; k < DIV; k++) txq.push_back(1'b1);
                if (loop) rq.push_back({tx_data, 2'b00});
            end
            if (rx_valid) begin
                if (rq.size() == 0) begin
                    check("rx_spurious_valid", rx_valid, 0);
                end else begin
                    e = rq.pop_front();
                    check("rx_data", rx_data, e[9:2]);
                    check("rx_frame_err", rx_frame_err, e[1]);
                    check("rx_parity_err", rx_parity_err, e[0]);
                    last_d = e[9:2];
                end
            end else begin
                check("rx_data_hold", rx_data, last_d);
                check("rx_idle_flags", {rx_frame_err, rx_parity_err}, 0);
            end
        end
    end

    task automatic send_tx(input logic [7:0] d, input bit keep);
        int n = 0;
        tx_data = d;
        tx_valid = 1'b1;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!acc && n < 400);
        if (!acc) check("tx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        tx_valid = keep;
    endtask

    task automatic hold(input logic b, input int n);
        rx_drv = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] d, input bit ferr, input bit pflip, input int stop_low);
        rq.push_back({d, ferr, pflip & PEN});
        hold(1'b0, DIV);
        for (int i = 0; i < 8; i++) hold(d[i], DIV);
        if (PEN) hold(^d ^ pflip, DIV);
        if (ferr) hold(1'b0, stop_low);
        hold(1'b1, 2 * DIV);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_tx(8'h41, 1'b0);
        repeat (110) @(posedge clk);
        #1;
        loop = 1'b1;
        send_tx(8'h00, 1'b1);
        send_tx(8'hA5, 1'b1);
        send_tx(8'hFF, 1'b0);
        repeat (140) @(posedge clk);
        #1;
        loop = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 30);
        send_rx(8'h3C, 1'b0, 1'b0, 0);
        send_rx(8'h55, 1'b1, 1'b0, 30);
        send_rx(8'h12, 1'b0, 1'b0, 0);
`ifdef UART_PARITY_EN
        send_rx(8'h07, 1'b0, 1'b1, 0);
        send_tx(8'h07, 1'b0);
        repeat (120) @(posedge clk);
        #1;
`endif
        for (int it = 0; it < 18; it++) begin
            int mode;
            logic [7:0] a, b;
            mode = $urandom_range(0, 3);
            a = 8'($urandom);
            b = 8'($urandom);
            if (mode == 0) begin
                loop = 1'b1;
                send_tx(a, 1'b0);
                repeat (130) @(posedge clk);
                #1;
            end else if (mode == 1) begin
                loop = 1'b0;
                send_rx(a, $urandom_range(0, 3) == 0, PEN && ($urandom_range(0, 1) == 1), $urandom_range(DIV, 3 * DIV));
            end else if (mode == 2) begin
                loop = 1'b0;
                fork
                    send_tx(a, 1'b0);
                    send_rx(b, 1'b0, 1'b0, 0);
                join
                repeat (130) @(posedge clk);
                #1;
            end else begin
                loop = 1'b1;
                send_tx(a, 1'b1);
                send_tx(b, 1'b1);
                send_tx(a ^ b, 1'b0);
                repeat (140) @(posedge clk);
                #1;
            end
            loop = 1'b0;
        end
        loop = 1'b1;
        send_tx(8'($urandom), 1'b0);
        repeat (45) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_ready", tx_ready, 0);
        check("rst_async_rx_valid", rx_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        send_tx(8'h5A, 1'b0);
        repeat (130) @(posedge clk);
        #1;
        check("rx_pending", rq.size(), 0);
        check("tx_pending", txq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
